obi_bank_rr_arbiter: RTL

- N-to-1 OBI arbiter/sequencer for one shared slave port on the system bus (e.g. MEMORY_RAM0 or MEMORY_RAM1 bank).
- Placed between the NtoM crossbar master ports and the bank.
- Shares the bank between the core instr/data masters and the external master using round-robin priority.
- Tracks outstanding transactions so each response is returned to the master that issued it.

---
 rtl/obi_bank_rr_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/obi_bank_rr_arbiter.sv
// ----------------------------------------------------------------------------
// obi_bank_rr_arbiter
//
// N-to-1 OBI arbiter for one shared memory bank. It sits between the crossbar
// master ports and the bank slave port. Requests are arbitrated round-robin.
// A request that the bank has not yet granted is locked, so its address and
// data stay stable. The index of each accepted master is recorded in an
// in-order ID FIFO, so every response is returned to the master that issued
// it.
//
// Ports
//   clk_i, rst_ni     clock, synchronous active-low reset
//   m_req_i           per-master request
//   m_addr_i          per-master address, packed, master 0 in the LSBs
//   m_we_i            per-master write enable
//   m_be_i            per-master byte enables, packed
//   m_wdata_i         per-master write data, packed
//   m_gnt_o           per-master grant (one-hot or zero)
//   m_rvalid_o        per-master response valid (one-hot or zero)
//   m_rdata_o         response data, broadcast to all masters
//   s_*               bank-side OBI request/response
//   outstanding_o     accepted-but-unanswered transaction count
//   resp_err_o        pulse: response arrived with nothing outstanding
// ----------------------------------------------------------------------------
module obi_bank_rr_arbiter #(
    parameter int unsigned NMASTER         = 7,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NMASTER-1:0]                     m_req_i,
    input  logic [NMASTER*AW-1:0]                  m_addr_i,
    input  logic [NMASTER-1:0]                     m_we_i,
    input  logic [NMASTER*(DW/8)-1:0]              m_be_i,
    input  logic [NMASTER*DW-1:0]                  m_wdata_i,
    output logic [NMASTER-1:0]                     m_gnt_o,
    output logic [NMASTER-1:0]                     m_rvalid_o,
    output logic [DW-1:0]                          m_rdata_o,
    output logic                                   s_req_o,
    output logic [AW-1:0]                          s_addr_o,
    output logic                                   s_we_o,
    output logic [DW/8-1:0]                        s_be_o,
    output logic [DW-1:0]                          s_wdata_o,
    input  logic                                   s_gnt_i,
    input  logic                                   s_rvalid_i,
    input  logic [DW-1:0]                          s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   resp_err_o
);

    localparam int unsigned IdxW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned BW   = DW / 8;

    // Arbitration state
    logic [IdxW-1:0] rr_q;
    logic            lock_q;
    logic [IdxW-1:0] lock_idx_q;

    // Response-ID FIFO
    logic [IdxW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;

    logic [IdxW-1:0] rr_win;
    logic            rr_found;
    logic [IdxW-1:0] win;
    logic            win_valid;
    logic            full;
    logic            empty;
    logic            hs;
    logic            pop;
    logic [IdxW-1:0] head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search starting at rr_q
    always_comb begin
        int unsigned cand;
        rr_win   = rr_q;
        rr_found = 1'b0;
        cand     = 0;
        for (int unsigned k = 0; k < NMASTER; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= NMASTER) begin
                cand = cand - NMASTER;
            end
            if (!rr_found && m_req_i[IdxW'(cand)]) begin
                rr_win   = IdxW'(cand);
                rr_found = 1'b1;
            end
        end
    end

    // A locked master that drops its request is never granted; the lock is
    // released on the next edge instead.
    assign win       = lock_q ? lock_idx_q : rr_win;
    assign win_valid = lock_q ? m_req_i[lock_idx_q] : rr_found;

    assign full  = (cnt_q == CntW'(MAX_OUTSTANDING));
    assign empty = (cnt_q == '0);

    // Full is evaluated on registered occupancy only, so a same-cycle pop
    // never opens the request path (no s_rvalid_i -> s_req_o path).
    assign s_req_o    = win_valid && !full;
    assign hs         = s_req_o && s_gnt_i;
    assign pop        = s_rvalid_i && !empty;
    assign resp_err_o = s_rvalid_i && empty;
    assign head       = fifo_q[rd_ptr_q];

    assign m_rdata_o     = s_rdata_i;
    assign outstanding_o = cnt_q;

    always_comb begin
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (s_req_o) begin
            s_addr_o  = m_addr_i[win*AW +: AW];
            s_we_o    = m_we_i[win];
            s_be_o    = m_be_i[win*BW +: BW];
            s_wdata_o = m_wdata_i[win*DW +: DW];
        end
    end

    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        if (hs) begin
            m_gnt_o[win] = 1'b1;
        end
        if (pop) begin
            m_rvalid_o[head] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (hs) begin
                rr_q   <= (win == IdxW'(NMASTER - 1)) ? '0 : win + 1'b1;
                lock_q <= 1'b0;
            end else if (s_req_o) begin
                // Bank stalled: hold this master until it is granted
                lock_q     <= 1'b1;
                lock_idx_q <= win;
            end else if (lock_q && !m_req_i[lock_idx_q]) begin
                lock_q <= 1'b0;
            end

            if (hs) begin
                fifo_q[wr_ptr_q] <= win;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end

            if (hs && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!hs && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule
